// File: rtl/read_phy.sv
// MDIO clause-22 read master: shifts out preamble/ST/OP/addresses, releases the
// pad for turnaround, then samples 16 data bits from the PHY on i_mdc.
module read_phy #(
  parameter int PRE_LEN = 32
) (
  input  logic        i_mdc,
  input  logic        i_rst_n,
  input  logic        i_read_en,
  input  logic [4:0]  i_phy_ad,
  input  logic [4:0]  i_phyreg_ad,
  input  logic        i_phydata_in,
  output logic        o_phydata_out,
  output logic        o_phydata_oe,
  output logic        o_mdc_en,
  output logic [15:0] o_read_data,
  output logic        o_read_phy_Dn,
  output logic        o_ta_err
);

  typedef enum logic [3:0] {IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, DONE} state_t;

  localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [4:0]  phy_q, phy_n, reg_q, reg_n;
  logic [15:0] sr, sr_n, rd_n;
  logic        out_n, oe_n, mdc_n, dn_n, ta_n;

  always_ff @(posedge i_mdc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      phy_q         <= '0;
      reg_q         <= '0;
      sr            <= '0;
      o_phydata_out <= 1'b0;
      o_phydata_oe  <= 1'b0;
      o_mdc_en      <= 1'b0;
      o_read_data   <= '0;
      o_read_phy_Dn <= 1'b0;
      o_ta_err      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      phy_q         <= phy_n;
      reg_q         <= reg_n;
      sr            <= sr_n;
      o_phydata_out <= out_n;
      o_phydata_oe  <= oe_n;
      o_mdc_en      <= mdc_n;
      o_read_data   <= rd_n;
      o_read_phy_Dn <= dn_n;
      o_ta_err      <= ta_n;
    end
  end

  // state/cnt name the bit that the coming edge puts on the outputs; in DATA the
  // same edge samples the bit presented one period earlier, hence cnt runs 0..16.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phy_n   = phy_q;
    reg_n   = reg_q;
    sr_n    = sr;
    out_n   = 1'b0;
    oe_n    = 1'b0;
    mdc_n   = o_mdc_en;
    rd_n    = o_read_data;
    dn_n    = o_read_phy_Dn;
    ta_n    = o_ta_err;
    if (state != IDLE && !i_read_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      mdc_n   = 1'b0;
      dn_n    = 1'b0;
    end else begin
      case (state)
        IDLE: if (i_read_en) begin
          state_n = PRE;
          cnt_n   = '0;
          mdc_n   = 1'b1;
          ta_n    = 1'b0;
          phy_n   = i_phy_ad;
          reg_n   = i_phyreg_ad;
        end
        PRE: begin
          oe_n  = 1'b1;
          out_n = 1'b1;
          if (cnt == PRE_LAST) begin state_n = ST; cnt_n = '0; end
          else cnt_n = cnt + 5'd1;
        end
        ST: begin
          oe_n  = 1'b1;
          out_n = cnt[0];
          if (cnt[0]) begin state_n = OP; cnt_n = '0; end
          else cnt_n = cnt + 5'd1;
        end
        OP: begin
          oe_n  = 1'b1;
          out_n = ~cnt[0];
          if (cnt[0]) begin state_n = PHYAD; cnt_n = '0; end
          else cnt_n = cnt + 5'd1;
        end
        PHYAD: begin
          oe_n  = 1'b1;
          out_n = phy_q[3'd4 - cnt[2:0]];
          if (cnt == 5'd4) begin state_n = REGAD; cnt_n = '0; end
          else cnt_n = cnt + 5'd1;
        end
        REGAD: begin
          oe_n  = 1'b1;
          out_n = reg_q[3'd4 - cnt[2:0]];
          if (cnt == 5'd4) begin state_n = TA; cnt_n = '0; end
          else cnt_n = cnt + 5'd1;
        end
        TA: begin
          if (cnt[0]) begin state_n = DATA; cnt_n = '0; end
          else cnt_n = cnt + 5'd1;
        end
        DATA: begin
          if (cnt == 5'd0) ta_n = i_phydata_in;
          else sr_n = {sr[14:0], i_phydata_in};
          if (cnt == 5'd16) begin
            rd_n    = {sr[14:0], i_phydata_in};
            dn_n    = 1'b1;
            mdc_n   = 1'b0;
            state_n = DONE;
            cnt_n   = '0;
          end else cnt_n = cnt + 5'd1;
        end
        DONE: ;
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          mdc_n   = 1'b0;
          dn_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_phy.sv
// Directed bench for read_phy: dut0 uses PRE_LEN=32, dut1 uses PRE_LEN=1; the
// bench plays the PHY on the shared pad input and checks every bit period.
module tb_read_phy;
  logic             i_mdc, i_rst_n;
  logic [1:0]       ren;
  logic [4:0]       i_phy_ad, i_phyreg_ad;
  logic             din;
  logic [1:0]       out_w, oe_w, mdc_w, dn_w, ta_w;
  logic [1:0][15:0] rd_w;
  int checks = 0;
  int errors = 0;

  read_phy #(.PRE_LEN(32)) dut0 (
    .i_mdc(i_mdc), .i_rst_n(i_rst_n), .i_read_en(ren[0]), .i_phy_ad(i_phy_ad),
    .i_phyreg_ad(i_phyreg_ad), .i_phydata_in(din), .o_phydata_out(out_w[0]),
    .o_phydata_oe(oe_w[0]), .o_mdc_en(mdc_w[0]), .o_read_data(rd_w[0]),
    .o_read_phy_Dn(dn_w[0]), .o_ta_err(ta_w[0]));

  read_phy #(.PRE_LEN(1)) dut1 (
    .i_mdc(i_mdc), .i_rst_n(i_rst_n), .i_read_en(ren[1]), .i_phy_ad(i_phy_ad),
    .i_phyreg_ad(i_phyreg_ad), .i_phydata_in(din), .o_phydata_out(out_w[1]),
    .o_phydata_oe(oe_w[1]), .o_mdc_en(mdc_w[1]), .o_read_data(rd_w[1]),
    .o_read_phy_Dn(dn_w[1]), .o_ta_err(ta_w[1]));

  initial i_mdc = 1'b0;
  always #5 i_mdc = ~i_mdc;

  // Caller is at a negedge; the next posedge is E0.
  // mode 0: full frame; 1: drop i_read_en after bit stop_n; 2: assert reset after bit stop_n.
  task automatic run_frame(input int sel, input int p, input logic [4:0] pa, input logic [4:0] ra,
                           input logic ta2, input logic [15:0] d, input logic [15:0] prev,
                           input int mode, input int stop_n);
    logic exp_oe, exp_out;
    logic [19:0] got, exp;
    i_phy_ad = pa; i_phyreg_ad = ra; din = 1'b1; ren[sel] = 1'b1;
    @(posedge i_mdc); #1;
    checks++;
    if ({mdc_w[sel], ta_w[sel], dn_w[sel]} !== 3'b100) begin
      errors++;
      $display("FAIL e0_start sel=%0d got mdc/ta/dn=%b%b%b want 100", sel, mdc_w[sel], ta_w[sel], dn_w[sel]);
    end
    i_phy_ad = ~pa; i_phyreg_ad = ~ra;
    for (int n = 0; n < p + 32; n++) begin
      @(posedge i_mdc); #1;
      exp_oe = 1'b1;
      if (n < p) exp_out = 1'b1;
      else if (n < p + 2) exp_out = (n == p + 1);
      else if (n < p + 4) exp_out = (n == p + 2);
      else if (n < p + 9) exp_out = pa[4 - (n - p - 4)];
      else if (n < p + 14) exp_out = ra[4 - (n - p - 9)];
      else begin exp_oe = 1'b0; exp_out = 1'b0; end
      got = {oe_w[sel], out_w[sel], mdc_w[sel], dn_w[sel], rd_w[sel]};
      exp = {exp_oe, exp_out, 1'b1, 1'b0, prev};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_bit sel=%0d n=%0d got oe/out/mdc/dn/rd=%h want %h", sel, n, got, exp);
      end
      if (mode == 1 && n == stop_n) begin
        ren[sel] = 1'b0;
        @(posedge i_mdc); #1;
        checks++;
        if ({oe_w[sel], mdc_w[sel], dn_w[sel], ta_w[sel], rd_w[sel]} !== {4'b000, ta2, prev}) begin
          errors++;
          $display("FAIL abort sel=%0d got oe/mdc/dn/ta=%b%b%b%b rd=%h want 000%b rd=%h", sel,
                   oe_w[sel], mdc_w[sel], dn_w[sel], ta_w[sel], rd_w[sel], ta2, prev);
        end
        return;
      end
      if (mode == 2 && n == stop_n) begin
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({oe_w[sel], out_w[sel], mdc_w[sel], dn_w[sel], ta_w[sel], rd_w[sel]} !== 21'h0) begin
          errors++;
          $display("FAIL reset_mid sel=%0d got oe/out/mdc/dn/ta=%b%b%b%b%b rd=%h want all zero", sel,
                   oe_w[sel], out_w[sel], mdc_w[sel], dn_w[sel], ta_w[sel], rd_w[sel]);
        end
        return;
      end
      if (n == p + 15) din = ta2;
      else if (n >= p + 16) din = d[15 - (n - p - 16)];
      else din = 1'b1;
    end
    @(posedge i_mdc); #1;
    checks++;
    if ({rd_w[sel], dn_w[sel], ta_w[sel], mdc_w[sel], oe_w[sel]} !== {d, 1'b1, ta2, 2'b00}) begin
      errors++;
      $display("FAIL done sel=%0d got rd=%h dn=%b ta=%b mdc=%b oe=%b want rd=%h dn=1 ta=%b mdc=0 oe=0",
               sel, rd_w[sel], dn_w[sel], ta_w[sel], mdc_w[sel], oe_w[sel], d, ta2);
    end
  endtask

  task automatic go_idle(input int sel, input logic [15:0] rd_exp);
    @(negedge i_mdc); ren[sel] = 1'b0;
    @(posedge i_mdc); #1;
    checks++;
    if ({dn_w[sel], mdc_w[sel], oe_w[sel], rd_w[sel]} !== {3'b000, rd_exp}) begin
      errors++;
      $display("FAIL to_idle sel=%0d got dn/mdc/oe=%b%b%b rd=%h want 000 rd=%h", sel,
               dn_w[sel], mdc_w[sel], oe_w[sel], rd_w[sel], rd_exp);
    end
    @(negedge i_mdc);
  endtask

  task automatic test_reset;
    ren = 2'b00; din = 1'b1; i_phy_ad = '0; i_phyreg_ad = '0;
    i_rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({oe_w[s], out_w[s], mdc_w[s], dn_w[s], ta_w[s], rd_w[s]} !== 21'h0) begin
        errors++;
        $display("FAIL reset sel=%0d got oe/out/mdc/dn/ta=%b%b%b%b%b rd=%h want all zero", s,
                 oe_w[s], out_w[s], mdc_w[s], dn_w[s], ta_w[s], rd_w[s]);
      end
    end
    @(negedge i_mdc); i_rst_n = 1'b1;
    @(negedge i_mdc);
  endtask

  task automatic test_basic;
    run_frame(0, 32, 5'h01, 5'h02, 1'b0, 16'hA5C3, 16'h0000, 0, 0);
  endtask

  task automatic test_hold_done;
    repeat (10) begin
      @(posedge i_mdc); #1;
      checks++;
      if ({dn_w[0], mdc_w[0], oe_w[0], rd_w[0]} !== {3'b100, 16'hA5C3}) begin
        errors++;
        $display("FAIL hold_done got dn/mdc/oe=%b%b%b rd=%h want 100 rd=a5c3", dn_w[0], mdc_w[0], oe_w[0], rd_w[0]);
      end
    end
    go_idle(0, 16'hA5C3);
  endtask

  task automatic test_no_phy;
    run_frame(0, 32, 5'h1F, 5'h11, 1'b1, 16'hFFFF, 16'hA5C3, 0, 0);
    go_idle(0, 16'hFFFF);
  endtask

  task automatic test_abort;
    // E0 of this frame must clear the ta_err left by the no-PHY frame.
    run_frame(0, 32, 5'h0C, 5'h15, 1'b0, 16'h1234, 16'hFFFF, 0, 0);
    go_idle(0, 16'h1234);
    run_frame(0, 32, 5'h0C, 5'h15, 1'b0, 16'hBEEF, 16'h1234, 1, 32 + 16 + 7);
    @(negedge i_mdc);
  endtask

  task automatic test_reset_mid;
    run_frame(0, 32, 5'h13, 5'h09, 1'b0, 16'h0F0F, 16'h1234, 2, 32 + 9);
    @(negedge i_mdc); i_rst_n = 1'b1;
    run_frame(0, 32, 5'h13, 5'h09, 1'b0, 16'h0F0F, 16'h0000, 0, 0);
    go_idle(0, 16'h0F0F);
  endtask

  task automatic test_pre_len1;
    run_frame(1, 1, 5'h1F, 5'h0A, 1'b0, 16'h5A3C, 16'h0000, 0, 0);
    go_idle(1, 16'h5A3C);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold_done;
    test_no_phy;
    test_abort;
    test_reset_mid;
    test_pre_len1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
